fir_filter_param: RTL and testbench



---
 rtl/fir_pkg.sv | 58 +++++
 rtl/fir_mac_unit.sv | 50 +++++
 rtl/fir_filter_param.sv | 145 ++++++++++++++
 tb/tb_fir_filter_param.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// ============================================================================
// Module      : fir_pkg
// Description : Shared types and helper functions for the parametrised FIR core
// Revision    : 1.0
// ============================================================================
`default_nettype none

package fir_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_OUT  = 2'd2
  } fir_state_t;

  // Saturation works on a fixed wide carrier so one function serves any width pair
  localparam int SAT_W = 64;

  typedef struct packed {
    logic                    sat;
    logic signed [SAT_W-1:0] value;
  } sat_res_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  function automatic int acc_width(input int data_w, input int coef_w, input int taps);
    return data_w + coef_w + clog2(taps);
  endfunction

  function automatic sat_res_t saturate(input logic signed [SAT_W-1:0] v, input int out_w);
    logic signed [SAT_W-1:0] max_v;
    logic signed [SAT_W-1:0] min_v;
    sat_res_t                res;
    max_v = $signed((SAT_W'(1) << (out_w - 1)) - SAT_W'(1));
    min_v = ~max_v;
    if (v > max_v) begin
      res.sat   = 1'b1;
      res.value = max_v;
    end else if (v < min_v) begin
      res.sat   = 1'b1;
      res.value = min_v;
    end else begin
      res.sat   = 1'b0;
      res.value = v;
    end
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fir_mac_unit.sv
// ============================================================================
// Module      : fir_mac_unit
// Description : Signed single-multiplier multiply-accumulate datapath
// Revision    : 1.0
// ============================================================================
`default_nettype none

module fir_mac_unit
  import fir_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int ACC_W  = 19
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] i_x,
  input  logic [COEF_W-1:0] i_h,
  input  logic              i_clear,
  input  logic              i_en,
  output logic [ACC_W-1:0]  o_acc,
  output logic [ACC_W-1:0]  o_sum
);

  localparam int PROD_W = DATA_W + COEF_W;

  logic signed [PROD_W-1:0] w_prod;
  logic signed [ACC_W-1:0]  w_sum;
  logic signed [ACC_W-1:0]  r_acc;

  assign w_prod = PROD_W'($signed(i_x)) * PROD_W'($signed(i_h));
  assign w_sum  = r_acc + ACC_W'(w_prod);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (i_clear) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= w_sum;
    end
  end

  assign o_acc = r_acc;
  // The final tap's sum leaves combinationally so the top can register it directly
  assign o_sum = w_sum;

endmodule

`default_nettype wire

// File: rtl/fir_filter_param.sv
// ============================================================================
// Module      : fir_filter_param
// Description : Time-multiplexed signed FIR with runtime coefficient loading
// Revision    : 1.0
// ============================================================================
`default_nettype none

module fir_filter_param
  import fir_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int TAPS   = 8,
  parameter int OUT_W  = 11,
  parameter int SHIFT  = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] s_tdata,
  input  logic              s_tvalid,
  output logic              s_tready,
  input  logic              s_coef_load,
  output logic [OUT_W-1:0]  m_tdata,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic              m_sat,
  output logic              busy
);

  localparam int             ACC_W  = acc_width(DATA_W, COEF_W, TAPS);
  localparam int             K_W    = clog2(TAPS);
  localparam logic [K_W-1:0] K_LAST = K_W'(TAPS - 1);

  if (COEF_W > DATA_W) begin : g_check_coef_w
    $error("fir_filter_param: COEF_W must not exceed DATA_W");
  end
  if (TAPS < 2) begin : g_check_taps
    $error("fir_filter_param: TAPS must be at least 2");
  end

  fir_state_t              r_state;
  logic [DATA_W-1:0]       r_x [TAPS];
  logic [COEF_W-1:0]       r_h [TAPS];
  logic [K_W-1:0]          r_k;
  logic [OUT_W-1:0]        r_m_tdata;
  logic                    r_m_tvalid;
  logic                    r_m_sat;

  logic                    w_accept;
  logic                    w_load;
  logic                    w_sample;
  logic [ACC_W-1:0]        w_acc;
  logic [ACC_W-1:0]        w_sum;
  logic signed [ACC_W-1:0] w_shifted;
  logic signed [SAT_W-1:0] w_wide;
  sat_res_t                w_res;
  logic                    w_unused;

  assign s_tready = (r_state == ST_IDLE);
  assign busy     = (r_state != ST_IDLE);
  assign m_tdata  = r_m_tdata;
  assign m_tvalid = r_m_tvalid;
  assign m_sat    = r_m_sat;

  assign w_accept = s_tvalid & s_tready;
  assign w_load   = w_accept & s_coef_load;
  assign w_sample = w_accept & ~s_coef_load;

  fir_mac_unit #(
    .DATA_W (DATA_W),
    .COEF_W (COEF_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_x     (r_x[r_k]),
    .i_h     (r_h[r_k]),
    .i_clear (w_sample),
    .i_en    (r_state == ST_MAC),
    .o_acc   (w_acc),
    .o_sum   (w_sum)
  );

  assign w_shifted = $signed(w_sum) >>> SHIFT;
  assign w_wide    = SAT_W'(w_shifted);
  assign w_res     = saturate(w_wide, OUT_W);
  assign w_unused  = ^{w_acc, w_res.value[SAT_W-1:OUT_W]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_k        <= '0;
      r_m_tdata  <= '0;
      r_m_tvalid <= 1'b0;
      r_m_sat    <= 1'b0;
      for (int i = 0; i < TAPS; i++) begin
        r_x[i] <= '0;
        r_h[i] <= (i == 0) ? COEF_W'(1) : '0;
      end
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_load) begin
            // New coefficients invalidate history, so the delay line restarts from zero
            for (int i = 0; i < TAPS - 1; i++) begin
              r_h[i] <= r_h[i+1];
            end
            r_h[TAPS-1] <= s_tdata[COEF_W-1:0];
            for (int i = 0; i < TAPS; i++) begin
              r_x[i] <= '0;
            end
          end else if (w_sample) begin
            r_x[0] <= s_tdata;
            for (int i = 1; i < TAPS; i++) begin
              r_x[i] <= r_x[i-1];
            end
            r_k     <= '0;
            r_state <= ST_MAC;
          end
        end
        ST_MAC: begin
          if (r_k == K_LAST) begin
            r_m_tdata  <= w_res.value[OUT_W-1:0];
            r_m_sat    <= w_res.sat;
            r_m_tvalid <= 1'b1;
            r_k        <= '0;
            r_state    <= ST_OUT;
          end else begin
            r_k <= r_k + K_W'(1);
          end
        end
        ST_OUT: begin
          if (m_tready) begin
            r_m_tvalid <= 1'b0;
            r_state    <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fir_filter_param.sv
// ============================================================================
// Module      : tb_fir_filter_param
// Description : Scoreboard bench for fir_filter_param with directed vectors
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_fir_filter_param;

  localparam int DATA_W = 8;
  localparam int COEF_W = 8;
  localparam int TAPS   = 8;
  localparam int OUT_W  = 11;
  localparam int SHIFT  = 0;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [DATA_W-1:0] s_tdata;
  logic              s_tvalid;
  logic              s_tready;
  logic              s_coef_load;
  logic [OUT_W-1:0]  m_tdata;
  logic              m_tvalid;
  logic              m_tready;
  logic              m_sat;
  logic              busy;

  fir_filter_param #(
    .DATA_W (DATA_W),
    .COEF_W (COEF_W),
    .TAPS   (TAPS),
    .OUT_W  (OUT_W),
    .SHIFT  (SHIFT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .s_tdata     (s_tdata),
    .s_tvalid    (s_tvalid),
    .s_tready    (s_tready),
    .s_coef_load (s_coef_load),
    .m_tdata     (m_tdata),
    .m_tvalid    (m_tvalid),
    .m_tready    (m_tready),
    .m_sat       (m_sat),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   data;
    logic sat;
    int   acc_cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!s_tready && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!s_tready) begin
      checks++;
      errors++;
      $display("FAIL s_tready_timeout: got 0, expected 1");
    end
  endtask

  task automatic send(input int d, input logic coef, input logic track,
                      input int exp_d, input logic exp_s);
    exp_t e;
    wait_ready();
    s_tdata     = DATA_W'(d);
    s_coef_load = coef;
    s_tvalid    = 1'b1;
    @(posedge clk);
    #1;
    s_tvalid    = 1'b0;
    s_coef_load = 1'b0;
    if (track && !coef) begin
      e.data    = exp_d;
      e.sat     = exp_s;
      e.acc_cyc = cyc;
      sb.push_back(e);
    end
  endtask

  task automatic sample(input int d, input int exp_d, input logic exp_s);
    send(d, 1'b0, 1'b1, exp_d, exp_s);
  endtask

  task automatic load_coefs(input int c [TAPS]);
    for (int i = 0; i < TAPS; i++) send(c[i], 1'b1, 1'b0, 0, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_s_tready"}, int'(s_tready), 1);
    check({tag, "_m_tvalid"}, int'(m_tvalid), 0);
    check({tag, "_m_tdata"}, int'(m_tdata), 0);
    check({tag, "_m_sat"}, int'(m_sat), 0);
    check({tag, "_busy"}, int'(busy), 0);
  endtask

  // Monitor: checks latency when an output first appears, data on each handshake
  initial begin
    exp_t e;
    logic prev_v;
    prev_v = 1'b0;
    forever begin
      @(negedge clk);
      if (m_tvalid && !prev_v) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got %0d, expected no output", int'($signed(m_tdata)));
        end else begin
          check("latency", cyc - sb[0].acc_cyc, TAPS);
        end
      end
      if (m_tvalid && m_tready && sb.size() > 0) begin
        e = sb.pop_front();
        check("m_tdata", int'($signed(m_tdata)), e.data);
        check("m_sat", int'(m_sat), int'(e.sat));
      end
      prev_v = m_tvalid;
    end
  end

  initial begin
    int c [TAPS];
    int n;
    s_tdata     = '0;
    s_tvalid    = 1'b0;
    s_coef_load = 1'b0;
    m_tready    = 1'b1;
    rst_n       = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Identity filtering straight out of reset
    sample(5, 5, 1'b0);
    sample(-3, -3, 1'b0);
    sample(127, 127, 1'b0);

    // Backpressure with ignored slave pulses
    wait_ready();
    m_tready = 1'b0;
    sample(42, 42, 1'b0);
    n = 0;
    while (!m_tvalid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("bp_valid_rise", int'(m_tvalid), 1);
    for (int i = 0; i < 5; i++) begin
      s_tvalid    = 1'b1;
      s_tdata     = DATA_W'(99);
      s_coef_load = i[0];
      @(posedge clk);
      #1;
      check("bp_hold_data", int'($signed(m_tdata)), 42);
      check("bp_hold_valid", int'(m_tvalid), 1);
      check("bp_s_tready", int'(s_tready), 0);
    end
    s_tvalid    = 1'b0;
    s_coef_load = 1'b0;
    m_tready    = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_idle", int'(s_tready), 1);
    check("bp_release_valid", int'(m_tvalid), 0);

    // All-ones coefficients, impulse response
    for (int i = 0; i < TAPS; i++) c[i] = 1;
    load_coefs(c);
    sample(10, 10, 1'b0);
    for (int i = 0; i < 7; i++) sample(0, 10, 1'b0);
    sample(0, 0, 1'b0);
    sample(0, 0, 1'b0);

    // h = 1,2,3,0... with a step input
    for (int i = 0; i < TAPS; i++) c[i] = 0;
    c[0] = 1;
    c[1] = 2;
    c[2] = 3;
    load_coefs(c);
    sample(1, 1, 1'b0);
    sample(1, 3, 1'b0);
    sample(1, 6, 1'b0);

    // Positive and negative saturation
    for (int i = 0; i < TAPS; i++) c[i] = 127;
    load_coefs(c);
    for (int i = 0; i < TAPS; i++) sample(127, 1023, 1'b1);
    load_coefs(c);
    for (int i = 0; i < TAPS; i++) sample(-128, -1024, 1'b1);

    // Reset in the middle of accumulation
    send(3, 1'b0, 1'b0, 0, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    check("mac_busy", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    sample(7, 7, 1'b0);

    n = 0;
    while (sb.size() > 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending, expected 0", sb.size());
    end
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
